// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//   Multi-channel edge detector for asynchronous level inputs. Each channel
//   has a synchroniser, an optional debounce filter, registered rise/fall/any
//   pulses, a mode-qualified event pulse, a saturating event counter and a
//   sticky event flag. irq is the OR of all sticky flags.
//
// Ports
//   clk         system clock, everything on posedge
//   rst_n       asynchronous active-low reset
//   sig_in      [CH]        asynchronous input levels
//   mode        [2*CH]      ch i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 any
//   cnt_clr     synchronous clear of every event counter (beats a coincident event)
//   flag_clr    [CH]        per-channel sticky flag clear (a coincident set wins)
//   rise_pulse  [CH]        1-cycle pulse per accepted rising edge
//   fall_pulse  [CH]        1-cycle pulse per accepted falling edge
//   evt_pulse   [CH]        1-cycle pulse per edge selected by mode
//   evt_cnt     [CH*CNT_W]  ch i at [i*CNT_W +: CNT_W], saturating evt_pulse count
//   evt_flag    [CH]        sticky, set by evt_pulse
//   irq         OR of evt_flag
// -----------------------------------------------------------------------------
module multi_edge_detect #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         sig_in,
    input  logic [2*CH-1:0]       mode,
    input  logic                  cnt_clr,
    input  logic [CH-1:0]         flag_clr,
    output logic [CH-1:0]         rise_pulse,
    output logic [CH-1:0]         fall_pulse,
    output logic [CH-1:0]         evt_pulse,
    output logic [CH*CNT_W-1:0]   evt_cnt,
    output logic [CH-1:0]         evt_flag,
    output logic                  irq
);

    // Debounce counter must be able to hold DEBOUNCE itself.
    localparam int                DB_W    = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]   DB_ONE  = DB_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_out;
            logic                   lvl_reg;
            logic                   lvl_d_reg;
            logic                   rise_reg;
            logic                   fall_reg;
            logic                   evt_reg;
            logic                   flag_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   rise_next;
            logic                   fall_next;
            logic                   evt_next;

            // Synchroniser chain; resets to 0, so an input held high through
            // reset release shows up as a rising edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in[gi]};
                end
            end

            assign sync_out = sync_reg[SYNC_STAGES-1];

            if (DEBOUNCE == 0) begin : g_nodb
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        lvl_reg <= 1'b0;
                    end else begin
                        lvl_reg <= sync_out;
                    end
                end
            end else begin : g_db
                logic [DB_W-1:0] db_cnt_reg;

                // A new level is accepted only after it has differed from the
                // filtered level on DEBOUNCE consecutive edges and still
                // differs on the next one; any agreement restarts the count.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        lvl_reg    <= 1'b0;
                        db_cnt_reg <= '0;
                    end else if (sync_out != lvl_reg) begin
                        if (db_cnt_reg == DB_MAX) begin
                            lvl_reg    <= sync_out;
                            db_cnt_reg <= '0;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DB_ONE;
                        end
                    end else begin
                        db_cnt_reg <= '0;
                    end
                end
            end

            assign rise_next = lvl_reg & ~lvl_d_reg;
            assign fall_next = ~lvl_reg & lvl_d_reg;
            // Mode is applied to the edge itself, so changing mode on a steady
            // level can never produce an event.
            assign evt_next  = (mode[2*gi+1] & fall_next) | (mode[2*gi] & rise_next);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lvl_d_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    evt_reg   <= 1'b0;
                end else begin
                    lvl_d_reg <= lvl_reg;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                    evt_reg   <= evt_next;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (evt_reg && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end

            // Set has priority over clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flag_reg <= 1'b0;
                end else begin
                    flag_reg <= evt_reg | (flag_reg & ~flag_clr[gi]);
                end
            end

            assign rise_pulse[gi]              = rise_reg;
            assign fall_pulse[gi]              = fall_reg;
            assign evt_pulse[gi]               = evt_reg;
            assign evt_flag[gi]                = flag_reg;
            assign evt_cnt[gi*CNT_W +: CNT_W]  = cnt_reg;
        end
    endgenerate

    assign irq = |evt_flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detect
//   Two instances share one stimulus: dut 0 without debounce, dut 1 with
//   DEBOUNCE=4; both use 3-bit counters. A history-based model predicts every
//   output each cycle; directed literal checks pin the model's key timings.
// -----------------------------------------------------------------------------
module tb_multi_edge_detect;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int DB   = 4;
    localparam int CW   = 3;
    localparam int HMAX = 4096;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [CH-1:0]     sig_in   = '0;
    logic [2*CH-1:0]   mode     = 8'hFF;
    logic              cnt_clr  = 1'b0;
    logic [CH-1:0]     flag_clr = '0;

    logic [CH-1:0]     d_rise [2];
    logic [CH-1:0]     d_fall [2];
    logic [CH-1:0]     d_evt  [2];
    logic [CH*CW-1:0]  d_cnt  [2];
    logic [CH-1:0]     d_flag [2];
    logic              d_irq  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_edge_detect #(.CH(CH), .SYNC_STAGES(S), .DEBOUNCE(0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .mode(mode), .cnt_clr(cnt_clr),
        .flag_clr(flag_clr), .rise_pulse(d_rise[0]), .fall_pulse(d_fall[0]),
        .evt_pulse(d_evt[0]), .evt_cnt(d_cnt[0]), .evt_flag(d_flag[0]), .irq(d_irq[0])
    );

    multi_edge_detect #(.CH(CH), .SYNC_STAGES(S), .DEBOUNCE(DB), .CNT_W(CW)) dut4 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .mode(mode), .cnt_clr(cnt_clr),
        .flag_clr(flag_clr), .rise_pulse(d_rise[1]), .fall_pulse(d_fall[1]),
        .evt_pulse(d_evt[1]), .evt_cnt(d_cnt[1]), .evt_flag(d_flag[1]), .irq(d_irq[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Keeps the input sampled at every edge since reset and derives the
    // accepted level from windows of that history.
    logic [CH-1:0] samp_h [HMAX];
    logic [CH-1:0] lvl_h  [2][HMAX];
    int            n = 0;

    logic [CH-1:0] exp_rise [2] = '{default: '0};
    logic [CH-1:0] exp_fall [2] = '{default: '0};
    logic [CH-1:0] exp_evt  [2] = '{default: '0};
    logic [CH-1:0] exp_flag [2] = '{default: '0};
    int            exp_cnt  [2][CH] = '{default: 0};

    logic [CH-1:0] m_nl, m_r, m_f, m_e, m_old;
    logic          m_all;
    int            m_d;

    // Synchronised value visible after edge m.
    function automatic logic [CH-1:0] syn_at(input int m);
        if (m - S + 1 < 0) return '0;
        return samp_h[m - S + 1];
    endfunction

    function automatic logic [CH-1:0] lvl_at(input int k, input int m);
        if (m < 0) return '0;
        return lvl_h[k][m];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            for (int k = 0; k < 2; k++) begin
                exp_rise[k] = '0;
                exp_fall[k] = '0;
                exp_evt[k]  = '0;
                exp_flag[k] = '0;
                for (int c = 0; c < CH; c++) exp_cnt[k][c] = 0;
            end
        end else begin
            if (n >= HMAX) begin
                $display("FAIL model history overflow");
                $fatal(1, "history overflow");
            end
            samp_h[n] = sig_in;
            for (int k = 0; k < 2; k++) begin
                m_d   = (k == 0) ? 0 : DB;
                m_old = lvl_at(k, n - 1);
                for (int c = 0; c < CH; c++) begin
                    if (m_d == 0) begin
                        m_nl[c] = syn_at(n - 1)[c];
                    end else begin
                        // Accept when the last DEBOUNCE+1 synchronised samples
                        // all disagree with the current level.
                        m_all = 1'b1;
                        for (int j = 0; j <= m_d; j++)
                            if (syn_at(n - 1 - j)[c] == m_old[c]) m_all = 1'b0;
                        m_nl[c] = m_all ? ~m_old[c] : m_old[c];
                    end
                end
                lvl_h[k][n] = m_nl;
                m_r = lvl_at(k, n - 1) & ~lvl_at(k, n - 2);
                m_f = ~lvl_at(k, n - 1) & lvl_at(k, n - 2);
                for (int c = 0; c < CH; c++)
                    m_e[c] = (mode[2*c] & m_r[c]) | (mode[2*c+1] & m_f[c]);
                for (int c = 0; c < CH; c++) begin
                    if (cnt_clr) exp_cnt[k][c] = 0;
                    else if (exp_evt[k][c] && exp_cnt[k][c] < CMAX) exp_cnt[k][c]++;
                end
                exp_flag[k] = exp_evt[k] | (exp_flag[k] & ~flag_clr);
                exp_rise[k] = m_r;
                exp_fall[k] = m_f;
                exp_evt[k]  = m_e;
            end
            n++;
        end
    end

    // -------------------------------------------------------- compare process
    int rise_seen [2][CH] = '{default: 0};
    int fall_seen [2][CH] = '{default: 0};
    int evt_seen  [2][CH] = '{default: 0};
    logic [CH*CW-1:0] ec;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) ec[c*CW +: CW] = CW'(exp_cnt[k][c]);
            check("rise_pulse", k, 32'(d_rise[k]), 32'(exp_rise[k]));
            check("fall_pulse", k, 32'(d_fall[k]), 32'(exp_fall[k]));
            check("evt_pulse",  k, 32'(d_evt[k]),  32'(exp_evt[k]));
            check("evt_cnt",    k, 32'(d_cnt[k]),  32'(ec));
            check("evt_flag",   k, 32'(d_flag[k]), 32'(exp_flag[k]));
            check("irq",        k, 32'(d_irq[k]),  32'(|exp_flag[k]));
            for (int c = 0; c < CH; c++) begin
                if (d_rise[k][c] === 1'b1) rise_seen[k][c]++;
                if (d_fall[k][c] === 1'b1) fall_seen[k][c]++;
                if (d_evt[k][c]  === 1'b1) evt_seen[k][c]++;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    function automatic int cnt_of(input int k, input int c);
        logic [CH*CW-1:0] v;
        v = d_cnt[k];
        return int'(v[c*CW +: CW]);
    endfunction

    task automatic wait_evt(input int k, input int c, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (d_evt[k][c] === 1'b1) seen = 1'b1;
        end
        check(name, k, 32'(seen), 32'd1);
    endtask

    int snap_r [2][CH];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_cnt",  k, 32'(d_cnt[k]),  32'd0);
            check("reset_flag", k, 32'(d_flag[k]), 32'd0);
            check("reset_irq",  k, 32'(d_irq[k]),  32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        tick(5);

        // 1: latency of a single rising edge on ch0
        sig_in[0] = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("t1_rise_early", 0, 32'(d_rise[0][0]), 32'd0);
        @(posedge clk); #1;
        check("t1_rise_lat", 0, 32'(d_rise[0][0]), 32'd1);
        check("t1_evt_lat",  0, 32'(d_evt[0][0]),  32'd1);
        @(posedge clk); #1;
        check("t1_rise_width", 0, 32'(d_rise[0][0]), 32'd0);
        repeat (2) @(posedge clk); #1;
        check("t1_db_early", 1, 32'(d_rise[1][0]), 32'd0);
        @(posedge clk); #1;
        check("t1_db_lat", 1, 32'(d_rise[1][0]), 32'd1);
        tick(6);
        for (int k = 0; k < 2; k++) begin
            check("t1_cnt",  k, 32'(cnt_of(k, 0)),    32'd1);
            check("t1_flag", k, 32'(d_flag[k][0]),    32'd1);
            check("t1_irq",  k, 32'(d_irq[k]),        32'd1);
        end

        // 2: short glitch on ch1 is filtered, longer pulse is accepted
        sig_in[1] = 1'b1; tick(3);
        sig_in[1] = 1'b0; tick(12);
        check("t2_glitch_drop", 1, 32'(rise_seen[1][1]), 32'd0);
        check("t2_glitch_pass", 0, 32'(rise_seen[0][1]), 32'd1);
        sig_in[1] = 1'b1; tick(6);
        sig_in[1] = 1'b0; tick(14);
        check("t2_long_rise", 1, 32'(rise_seen[1][1]), 32'd1);
        check("t2_long_fall", 1, 32'(fall_seen[1][1]), 32'd1);

        // 3: ch2 rise-only qualification, then mode off
        mode = 8'hDF;
        for (int t = 0; t < 4; t++) begin
            sig_in[2] = ~sig_in[2];
            tick(t == 3 ? 12 : 8);
        end
        for (int k = 0; k < 2; k++) begin
            check("t3_rise", k, 32'(rise_seen[k][2]), 32'd2);
            check("t3_fall", k, 32'(fall_seen[k][2]), 32'd2);
            check("t3_evt",  k, 32'(evt_seen[k][2]),  32'd2);
            check("t3_cnt",  k, 32'(cnt_of(k, 2)),    32'd2);
        end
        mode = 8'hCF;
        sig_in[2] = 1'b1; tick(8);
        sig_in[2] = 1'b0; tick(12);
        for (int k = 0; k < 2; k++) begin
            check("t3_off_cnt",  k, 32'(cnt_of(k, 2)),   32'd2);
            check("t3_off_flag", k, 32'(d_flag[k][2]),   32'd1);
            check("t3_off_evt",  k, 32'(evt_seen[k][2]), 32'd2);
        end

        // 4: saturation on ch3, then clear coincident with the 10th event
        for (int t = 0; t < 9; t++) begin
            sig_in[3] = ~sig_in[3];
            tick(8);
        end
        tick(4);
        for (int k = 0; k < 2; k++)
            check("t4_sat", k, 32'(cnt_of(k, 3)), 32'd7);
        sig_in[3] = ~sig_in[3];
        wait_evt(1, 3, "t4_evt_wait");
        cnt_clr = 1'b1;
        @(posedge clk); #2;
        cnt_clr = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("t4_clr", k, 32'(cnt_of(k, 3)), 32'd0);
        tick(4);

        // 5: flag clear coincident with event, then alone
        sig_in[0] = 1'b0;
        wait_evt(0, 0, "t5_evt_wait");
        flag_clr = 4'b0001;
        @(posedge clk); #2;
        flag_clr = 4'b0000;
        @(negedge clk);
        check("t5_set_wins", 0, 32'(d_flag[0][0]), 32'd1);
        tick(10);
        flag_clr = 4'b1110; tick(1);
        flag_clr = 4'b0000; tick(1);
        for (int k = 0; k < 2; k++) begin
            check("t5_keep_flag", k, 32'(d_flag[k][0]), 32'd1);
            check("t5_keep_irq",  k, 32'(d_irq[k]),     32'd1);
        end
        flag_clr = 4'b0001; tick(1);
        flag_clr = 4'b0000; tick(1);
        for (int k = 0; k < 2; k++) begin
            check("t5_clr_flag", k, 32'(d_flag[k]), 32'd0);
            check("t5_clr_irq",  k, 32'(d_irq[k]),  32'd0);
        end

        // 6: reset in the middle of activity, input held high through release
        sig_in = 4'hF; tick(12);
        check("t6_irq_before", 1, 32'(d_irq[1]), 32'd1);
        sig_in = 4'h0; tick(3);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("t6_rst_rise", k, 32'(d_rise[k]), 32'd0);
            check("t6_rst_fall", k, 32'(d_fall[k]), 32'd0);
            check("t6_rst_evt",  k, 32'(d_evt[k]),  32'd0);
            check("t6_rst_cnt",  k, 32'(d_cnt[k]),  32'd0);
            check("t6_rst_flag", k, 32'(d_flag[k]), 32'd0);
            check("t6_rst_irq",  k, 32'(d_irq[k]),  32'd0);
        end
        sig_in = 4'hF;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) snap_r[k][c] = rise_seen[k][c];
        tick(3);
        rst_n = 1'b1;
        tick(15);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++)
                check("t6_rel_rise", k, 32'(rise_seen[k][c] - snap_r[k][c]), 32'd1);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
